// File: rtl/sysarray_ctrl_pkg.sv
// Shared definitions for the systolic-array sequencer: FP lane width, neutral
// fill value, FSM encoding and drain-length helper.
package sysarray_ctrl_pkg;

  localparam int unsigned FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h00000000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Cycles spent in DRAIN so the last wavefront reaches PE(N-1,N-1) and settles
  function automatic int unsigned drain_len(input int unsigned n, input int unsigned pe_lat);
    return 2 * n + pe_lat - 1;
  endfunction

endpackage

// File: rtl/sysarray_ctrl_if.sv
// Control, operand-buffer and array-edge signals of the systolic-array sequencer.
interface sysarray_ctrl_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned KW = 16
);
  localparam int unsigned LW = N * sysarray_ctrl_pkg::FP_W;

  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic          res_valid;
  logic          pe_clr;
  logic          rd_en;
  logic [KW-1:0] rd_addr;
  logic [LW-1:0] rd_data_a;
  logic [LW-1:0] rd_data_b;
  logic [LW-1:0] left_o;
  logic [LW-1:0] up_o;

  modport master (
    output start, k_len, rd_data_a, rd_data_b,
    input  busy, done, res_valid, pe_clr, rd_en, rd_addr, left_o, up_o
  );

  modport slave (
    input  start, k_len, rd_data_a, rd_data_b,
    output busy, done, res_valid, pe_clr, rd_en, rd_addr, left_o, up_o
  );
endinterface

// File: rtl/sysarray_ctrl_skew_line.sv
// DEPTH-stage 32-bit delay line with a per-stage valid bit; invalid stages read
// back as FP zero so the MAC sees a neutral operand.
module sysarray_ctrl_skew_line
  import sysarray_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_vld,
  input  logic [FP_W-1:0] i_data,
  output logic [FP_W-1:0] o_data
);

  logic [DEPTH-1:0][FP_W-1:0] r_data;
  logic [DEPTH-1:0]           r_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_vld  <= '0;
    end else if (i_flush) begin
      r_data <= '0;
      r_vld  <= '0;
    end else begin
      r_data[0] <= i_data;
      r_vld[0]  <= i_vld;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
    end
  end

  assign o_data = r_vld[DEPTH-1] ? r_data[DEPTH-1] : FP_ZERO;

endmodule

// File: rtl/sysarray_ctrl.sv
// Sequencer for an N x N systolic MAC array: clears PEs, streams K operand
// slices with per-lane skew, waits for the wavefront to drain, then signals done.
module sysarray_ctrl
  import sysarray_ctrl_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned KW     = 16,
  parameter int unsigned PE_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  sysarray_ctrl_if.slave bus
);

  localparam int unsigned DRAIN = drain_len(N, PE_LAT);
  localparam int unsigned CW    = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam int unsigned LW    = N * FP_W;

  state_e        r_state, w_state_nxt;
  logic [KW-1:0] r_k, w_k_nxt;
  logic [KW-1:0] r_addr, w_addr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_pe_clr, w_pe_clr_nxt;
  logic          r_rd_en, w_rd_en_nxt;
  logic          r_rd_vld;
  logic          w_last_addr;
  logic [LW-1:0] w_left, w_up;

  assign w_last_addr = (r_addr == (r_k - KW'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pe_clr <= 1'b0;
      r_rd_en  <= 1'b0;
      r_rd_vld <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_addr   <= w_addr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_pe_clr <= w_pe_clr_nxt;
      r_rd_en  <= w_rd_en_nxt;
      r_rd_vld <= r_rd_en;
    end
  end

  // Next state, counters and next-cycle output values
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = '0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_CLEAR;
          w_k_nxt     = bus.k_len;
        end
      end
      S_CLEAR: w_state_nxt = (r_k != '0) ? S_FEED : S_DONE;
      S_FEED: begin
        w_cnt_nxt = CW'(DRAIN - 1);
        if (w_last_addr) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_cnt == '0) w_state_nxt = S_DONE;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt == S_FEED && r_state == S_FEED) w_addr_nxt = r_addr + KW'(1);

    w_busy_nxt   = (w_state_nxt != S_IDLE);
    w_done_nxt   = (w_state_nxt == S_DONE);
    w_pe_clr_nxt = (w_state_nxt == S_CLEAR);
    w_rd_en_nxt  = (w_state_nxt == S_FEED);
  end

  // Lane i of each edge is delayed i extra cycles to form the diagonal wavefront
  for (genvar gi = 0; gi < int'(N); gi++) begin : g_lane
    sysarray_ctrl_skew_line #(.DEPTH(gi + 1)) u_skew_a (
      .clk    (clk),
      .rst    (rst),
      .i_flush(r_pe_clr),
      .i_vld  (r_rd_vld),
      .i_data (bus.rd_data_a[gi*FP_W +: FP_W]),
      .o_data (w_left[gi*FP_W +: FP_W])
    );
    sysarray_ctrl_skew_line #(.DEPTH(gi + 1)) u_skew_b (
      .clk    (clk),
      .rst    (rst),
      .i_flush(r_pe_clr),
      .i_vld  (r_rd_vld),
      .i_data (bus.rd_data_b[gi*FP_W +: FP_W]),
      .o_data (w_up[gi*FP_W +: FP_W])
    );
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.res_valid = r_done;
  assign bus.pe_clr    = r_pe_clr;
  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_addr;
  assign bus.left_o    = w_left;
  assign bus.up_o      = w_up;

endmodule

// File: tb/tb_sysarray_ctrl.sv
// Self-checking bench for sysarray_ctrl: table of matmul runs plus reset corner
// sequences; lane outputs checked against a scoreboard of skewed operand slices.
module tb_sysarray_ctrl;

  localparam int unsigned N      = 4;
  localparam int unsigned KW     = 16;
  localparam int unsigned PE_LAT = 1;
  localparam int unsigned LW     = N * 32;

  typedef struct {
    int          k;
    int          done_cyc;
    int          xs0;
    int          xs1;
    logic [31:0] a0, b0, a1, b1;
    bit          zero_tail;
    bit          lane_xor;
    bit          b2b;
  } vec_t;

  typedef struct {
    int          cyc;
    int          lane;
    logic [31:0] a;
    logic [31:0] b;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   gcyc = 0;
  int   errors = 0;
  int   checks = 0;
  sb_t  sb[$];
  vec_t tbl[6];

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  sysarray_ctrl_if #(.N(N), .KW(KW)) bus ();

  sysarray_ctrl #(.N(N), .KW(KW), .PE_LAT(PE_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string nm, input int c, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, exp);
    end
  endtask

  function automatic logic [31:0] slice_val(input vec_t v, input int k, input int r, input bit isb);
    logic [31:0] x;
    if (k == 0)           x = isb ? v.b0 : v.a0;
    else if (k == 1)      x = isb ? v.b1 : v.a1;
    else if (v.zero_tail) x = 32'h0;
    else                  x = 32'h40000000 + 32'(k * 256) + (isb ? 32'h10 : 32'h0);
    if (v.lane_xor) x = x ^ (32'(r + 1) << 12);
    return x;
  endfunction

  task automatic drive_junk();
    for (int i = 0; i < int'(N); i++) begin
      bus.rd_data_a[i*32 +: 32] = $urandom | 32'h1;
      bus.rd_data_b[i*32 +: 32] = $urandom | 32'h1;
    end
  endtask

  task automatic check_lanes(input int c);
    logic [LW-1:0] el, eu;
    el = '0;
    eu = '0;
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].cyc == gcyc) begin
        el[sb[j].lane*32 +: 32] = sb[j].a;
        eu[sb[j].lane*32 +: 32] = sb[j].b;
        sb.delete(j);
      end
    end
    chk("left_o", c, bus.left_o, el);
    chk("up_o", c, bus.up_o, eu);
  endtask

  task automatic check_cycle(input vec_t v, input int c);
    logic [4:0] exp_c;
    bit         exp_en;
    exp_en = (v.k > 0) && (c >= 2) && (c <= v.k + 1);
    exp_c  = {(c >= 1 && c <= v.done_cyc), (c == v.done_cyc), (c == v.done_cyc), (c == 1), exp_en};
    chk("ctrl{busy,done,res_valid,pe_clr,rd_en}", c,
        LW'({bus.busy, bus.done, bus.res_valid, bus.pe_clr, bus.rd_en}), LW'(exp_c));
    if (exp_en) chk("rd_addr", c, LW'(bus.rd_addr), LW'(c - 2));
    check_lanes(c);
  endtask

  // One matmul: entered and left just after an active edge (cycle 0 / done cycle)
  task automatic run_vec(input vec_t v);
    bit            prev_en;
    logic [KW-1:0] prev_addr;
    logic [31:0]   a, b;
    check_cycle(v, 0);
    bus.start = 1'b1;
    bus.k_len = KW'(v.k);
    drive_junk();
    prev_en   = bus.rd_en;
    prev_addr = bus.rd_addr;
    for (int c = 1; c <= v.done_cyc; c++) begin
      @(posedge clk); #1;
      check_cycle(v, c);
      bus.start = (c == v.xs0) || (c == v.xs1);
      bus.k_len = KW'($urandom_range(1, 20));
      if (prev_en) begin
        for (int i = 0; i < int'(N); i++) begin
          a = slice_val(v, int'(prev_addr), i, 1'b0);
          b = slice_val(v, int'(prev_addr), i, 1'b1);
          bus.rd_data_a[i*32 +: 32] = a;
          bus.rd_data_b[i*32 +: 32] = b;
          sb.push_back('{cyc: gcyc + 1 + i, lane: i, a: a, b: b});
        end
      end else begin
        drive_junk();
      end
      prev_en   = bus.rd_en;
      prev_addr = bus.rd_addr;
    end
    chk("scoreboard_drained", v.done_cyc, LW'(sb.size()), LW'(0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_ctrl", i, LW'({bus.busy, bus.done, bus.res_valid, bus.pe_clr, bus.rd_en}), LW'(0));
      check_lanes(i);
      bus.start = 1'b0;
      drive_junk();
    end
  endtask

  task automatic check_all_zero(input string nm, input int c);
    chk({nm, "_ctrl"}, c, LW'({bus.busy, bus.done, bus.res_valid, bus.pe_clr, bus.rd_en}), LW'(0));
    chk({nm, "_rd_addr"}, c, LW'(bus.rd_addr), LW'(0));
    chk({nm, "_left_o"}, c, bus.left_o, '0);
    chk({nm, "_up_o"}, c, bus.up_o, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", gcyc);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{k: 1, done_cyc: 11, xs0: -1, xs1: -1,
               a0: 32'h3f800000, b0: 32'h3f800000, a1: 32'h0, b1: 32'h0,
               zero_tail: 1'b1, lane_xor: 1'b0, b2b: 1'b0};
    tbl[1] = '{k: 3, done_cyc: 13, xs0: -1, xs1: -1,
               a0: 32'h3d4779a7, b0: 32'h3d3f4880, a1: 32'hbe6f9db2, b1: 32'h3f000000,
               zero_tail: 1'b1, lane_xor: 1'b0, b2b: 1'b0};
    tbl[2] = '{k: 0, done_cyc: 2, xs0: -1, xs1: -1,
               a0: 32'h0, b0: 32'h0, a1: 32'h0, b1: 32'h0,
               zero_tail: 1'b0, lane_xor: 1'b0, b2b: 1'b0};
    tbl[3] = '{k: 5, done_cyc: 15, xs0: 3, xs1: 15,
               a0: 32'h11111111, b0: 32'h22222222, a1: 32'h33333333, b1: 32'h44444444,
               zero_tail: 1'b0, lane_xor: 1'b1, b2b: 1'b1};
    tbl[4] = '{k: 2, done_cyc: 12, xs0: -1, xs1: -1,
               a0: 32'h3f800000, b0: 32'hc0000000, a1: 32'h40400000, b1: 32'h40800000,
               zero_tail: 1'b0, lane_xor: 1'b1, b2b: 1'b0};
    tbl[5] = '{k: 7, done_cyc: 17, xs0: 10, xs1: -1,
               a0: 32'h5a5a5a5a, b0: 32'ha5a5a5a5, a1: 32'h0f0f0f0f, b1: 32'hf0f0f0f0,
               zero_tail: 1'b0, lane_xor: 1'b1, b2b: 1'b0};

    // Reset held with start asserted
    bus.start = 1'b1;
    bus.k_len = KW'(5);
    drive_junk();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst_hold", 0);
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b0;
    idle(2);

    // Reset asserted in the middle of FEED
    bus.start = 1'b1;
    bus.k_len = KW'(5);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk("midfeed_rd_en", 4, LW'(bus.rd_en), LW'(1));
    #2 rst = 1'b0;
    #1;
    check_all_zero("rst_midfeed", 4);
    for (int c = 5; c <= 16; c++) begin
      @(posedge clk); #1;
      chk("rst_no_done", c, LW'({bus.done, bus.busy}), LW'(0));
    end
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    idle(1);

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i]);
      if (tbl[i].b2b) begin
        @(posedge clk); #1;
      end else begin
        idle(3);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sysarray_ctrl.md
Name: sysarray_ctrl

Overview:
Sequencer for an N x N systolic array of sysblock FP32 MAC cells.
- On start, clears the PE accumulators.
- Reads K operand slices from the A/B operand buffers.
- Skews each lane so that row r and column c enter the array r and c cycles late.
- Waits for the wavefront to drain, then pulses done/res_valid so results are captured from every PE's res.

Parameters:
N, 4, array dimension (lanes per edge), 1..16
KW, 16, width of k_len and rd_addr
PE_LAT, 1, cycles from operands at a PE to updated res

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin a matmul; sampled only in IDLE
k_len  in  KW  inner dimension K; captured on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at completion
res_valid  out  1  same cycle as done; all PE res outputs final
pe_clr  out  1  one-cycle active-high synchronous clear to every PE rst
rd_en  out  1  operand buffer read strobe
rd_addr  out  KW  slice index k, 0..K-1
rd_data_a  in  N*32  A column k, lane r at bits [32r+31:32r]; valid 1 cycle after rd_en
rd_data_b  in  N*32  B row k, lane c likewise
left_o  out  N*32  skewed feed to the array left edge, lane r to row r
up_o  out  N*32  skewed feed to the array top edge, lane c to column c

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs go to 0: busy, done, res_valid, pe_clr, rd_en, rd_addr, left_o, up_o.
  - All skew registers and counters clear.
  - Reset mid-operation aborts with no done pulse.
  - After release, the first start is accepted normally.
- Cycle numbering: start is high in IDLE in cycle 0.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
  - IDLE: start=1 latches k_len into k_reg. Next state is CLEAR.
  - CLEAR (cycle 1): pe_clr=1. Skew pipelines are zeroed. Next state is FEED if k_reg!=0, else DONE.
  - FEED (cycles 2..K+1): rd_en=1 with rd_addr=0,1,..,K-1, one per cycle. After the last address (cycle F=K+1), go to DRAIN.
  - DRAIN: a counter runs so that DONE occupies cycle F+2N+PE_LAT.
  - DONE: done=1 and res_valid=1 for exactly 1 cycle, then IDLE with busy=0 in the next cycle.
- Skew:
  - Data read in cycle t arrives at t+1.
  - It is registered into lane 0 output at t+2.
  - Lane i (A and B) passes through i further registers, so lane i appears on left_o/up_o at cycle t+2+i.
  - Each lane register carries a valid bit. Where valid=0, the lane output is 32'h00000000 (zero-fill, neutral for the FP MAC).
- Arithmetic: rd_addr counts up modulo 2^KW but never wraps, since it stops at K-1. k_len=0 gives a CLEAR→DONE path with done at cycle 2.
- Simultaneous events:
  - start while busy is ignored; k_reg is unchanged.
  - start high during the DONE cycle is ignored.
  - The earliest restart is cycle DONE+1 (IDLE).
- k_len changes after acceptance have no effect.
- Data is never stalled. Buffers must return data with a fixed 1-cycle latency.

Decomposition:
- Shared include/package (sysarray_defs): FP_W=32, FP_ZERO=32'h00000000, and the state encodings (IDLE=0, CLEAR=1, FEED=2, DRAIN=3, DONE=4, 3-bit).
- The drain-length function 2N+PE_LAT-1 also lives there for reuse by the bench.
- One sub-module, skew_line: a parameterised DEPTH x 32-bit shift register with valid bit, asynchronous active-low reset and a synchronous flush input. It is instantiated 2N times with DEPTH=i+1.
- The FSM and counters stay in sysarray_ctrl.

Test Plan:
- Reset values: hold rst=0 with start=1 → all outputs 0, busy=0. Assert rst=0 mid-FEED → outputs 0 within the same cycle, no done pulse.
- K=1, N=4, PE_LAT=1, all lanes 32'h3f800000 (1.0):
  - pe_clr at cycle 1.
  - rd_en at cycle 2 with rd_addr=0.
  - left_o/up_o lane i = 3f800000 only in cycle 4+i, zero otherwise.
  - done/res_valid at cycle 11.
- K=3, lane data A=32'h3d4779a7 / B=32'h3d3f4880 for k=0 and A=32'hbe6f9db2 / B=32'h3f000000 for k=1:
  - rd_addr 0,1,2 in cycles 2,3,4.
  - Lane 2 shows k0 data at cycle 6.
  - done at cycle 13.
  - With real sysblocks, PE(0,0) res=32'hbdeaf550 when k=2 operands are zero.
- k_len=0 → pe_clr at cycle 1, no rd_en, done at cycle 2, feeds all zero.
- Start pulses during FEED and during DONE → ignored, single done. A start at DONE+1 is accepted, with pe_clr one cycle later.
